// File: rtl/button_press_detector_pkg.sv
// Shared types and default timing for the front-panel button conditioning blocks.
package clock_pkg;
  typedef enum logic [1:0] {IDLE, PRESSED, LONG_FIRED} press_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int LONG_CYCLES_DEFAULT     = 50000000;
endpackage

// File: rtl/button_press_detector_if.sv
// Pad input and event strobes of one button channel.
interface button_press_detector_if;
  logic button_raw;
  logic signal;
  logic signal_long;
  logic held;

  modport master (output button_raw, input signal, input signal_long, input held);
  modport slave  (input button_raw, output signal, output signal_long, output held);
endinterface

// File: rtl/button_press_detector_debouncer.sv
// Two-flop synchroniser plus stable-sample debounce; o_rise flags the cycle held is about to rise.
module debouncer
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_held,
  output logic o_rise
);
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1, r_sync2, r_held;
  logic [CW-1:0] r_cnt;
  logic          w_pressed, w_toggle;

  assign w_pressed = r_sync2 ^ ACTIVE_LOW;
  assign w_toggle  = (w_pressed != r_held) && (r_cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= ACTIVE_LOW;
      r_sync2 <= ACTIVE_LOW;
      r_held  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (w_pressed == r_held || w_toggle) r_cnt <= '0;
      else                                 r_cnt <= r_cnt + 1'b1;
      if (w_toggle) r_held <= ~r_held;
    end
  end

  assign o_held = r_held;
  assign o_rise = w_toggle & ~r_held;
endmodule

// File: rtl/button_press_detector.sv
// Classifies each debounced press as short (pulse on release) or long (pulse at hold threshold).
module button_press_detector
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  button_press_detector_if.slave  bus
);
  localparam int            HW        = $clog2(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  press_state_t  r_state, w_state_nxt;
  logic [HW-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic          r_signal, r_signal_long, w_signal_nxt, w_signal_long_nxt;
  logic          w_held, w_rise;

  debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_db (
    .clock  (clock),
    .reset  (reset),
    .i_raw  (bus.button_raw),
    .o_held (w_held),
    .o_rise (w_rise)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_hold_cnt    <= '0;
      r_signal      <= 1'b0;
      r_signal_long <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_signal      <= w_signal_nxt;
      r_signal_long <= w_signal_long_nxt;
    end
  end

  // Entering PRESSED on the rise strobe aligns hold_cnt with the edge held rises;
  // release is seen from the held register one edge later, so it beats the threshold.
  always_comb begin
    w_state_nxt       = r_state;
    w_hold_cnt_nxt    = r_hold_cnt;
    w_signal_nxt      = 1'b0;
    w_signal_long_nxt = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt    = PRESSED;
          w_hold_cnt_nxt = '0;
        end
      end
      PRESSED: begin
        if (!w_held) begin
          w_signal_nxt = 1'b1;
          w_state_nxt  = IDLE;
        end else if (r_hold_cnt == HOLD_LAST) begin
          w_signal_long_nxt = 1'b1;
          w_state_nxt       = LONG_FIRED;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end
      LONG_FIRED: begin
        if (!w_held) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    // With very short debounce a new press can land on the release cycle.
    if (r_state != IDLE && w_rise) begin
      w_state_nxt    = PRESSED;
      w_hold_cnt_nxt = '0;
    end
  end

  assign bus.signal      = r_signal;
  assign bus.signal_long = r_signal_long;
  assign bus.held        = w_held;
endmodule

// File: tb/tb_button_press_detector.sv
// Scoreboard bench: two instances (active-high and active-low pad) against a window-based press model.
module tb_button_press_detector;
  import clock_pkg::*;

  localparam int D    = 4;
  localparam int L    = 20;
  localparam int HMAX = 8192;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  button_press_detector_if bus0 ();
  button_press_detector_if bus1 ();

  button_press_detector #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0));
  button_press_detector #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1));

  typedef struct { bit is_long; int edge_no; } ev_t;
  ev_t q0[$];
  ev_t q1[$];

  int checks = 0;
  int errors = 0;
  bit pr [HMAX];
  bit held_exp [HMAX];
  int edge_n = -1;
  bit hm = 1'b0;
  int h_edge = -100000;

  function automatic bit sample(input int k);
    return (k >= 2) ? pr[k-2] : 1'b0;
  endfunction

  function automatic void push_ev(input bit lng, input int k);
    ev_t e;
    e.is_long = lng;
    e.edge_no = k;
    q0.push_back(e);
    q1.push_back(e);
  endfunction

  // held flips once the last D debouncer samples all disagree with it.
  function automatic void model_edge(input int k);
    bit tog = 1'b1;
    for (int j = k - D + 1; j <= k; j++)
      if (j < 0 || sample(j) == hm) tog = 1'b0;
    if (hm && k == h_edge + L) push_ev(1'b1, k);
    if (tog) begin
      if (!hm) h_edge = k;
      else if (k < h_edge + L) push_ev(1'b0, k + 1);
      hm = ~hm;
    end
    held_exp[k] = hm;
  endfunction

  task automatic step(input bit p);
    if (edge_n + 1 >= HMAX) begin
      $display("FAIL history overflow edge %0d", edge_n);
      $fatal(1, "history overflow");
    end
    bus0.button_raw = p;
    bus1.button_raw = ~p;
    pr[edge_n+1] = p;
    @(posedge clock);
    edge_n++;
    model_edge(edge_n);
    #1;
  endtask

  task automatic hold(input bit p, input int n);
    repeat (n) step(p);
  endtask

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d got %b expected %b", name, edge_n, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_held0"}, bus0.held, 1'b0);
    chk({tag, "_sig0"}, bus0.signal, 1'b0);
    chk({tag, "_long0"}, bus0.signal_long, 1'b0);
    chk({tag, "_held1"}, bus1.held, 1'b0);
    chk({tag, "_sig1"}, bus1.signal, 1'b0);
    chk({tag, "_long1"}, bus1.signal_long, 1'b0);
  endtask

  task automatic mon(input int id, input logic s, input logic sl);
    ev_t e;
    int  sz;
    checks++;
    if (s && sl) begin
      errors++;
      $display("FAIL both_pulses dut%0d at edge %0d got signal=1 signal_long=1 expected at most one", id, edge_n);
    end
    sz = (id == 0) ? q0.size() : q1.size();
    if (s || sl) begin
      checks++;
      if (sz == 0) begin
        errors++;
        $display("FAIL extra_pulse dut%0d at edge %0d got long=%0b expected no pulse", id, edge_n, sl);
      end else begin
        if (id == 0) e = q0.pop_front(); else e = q1.pop_front();
        if (e.is_long != sl || e.edge_no != edge_n) begin
          errors++;
          $display("FAIL pulse dut%0d got long=%0b at edge %0d expected long=%0b at edge %0d",
                   id, sl, edge_n, e.is_long, e.edge_no);
        end
      end
    end
    sz = (id == 0) ? q0.size() : q1.size();
    if (sz > 0) begin
      if (id == 0) e = q0[0]; else e = q1[0];
      if (e.edge_no <= edge_n) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse dut%0d got none expected long=%0b at edge %0d", id, e.is_long, e.edge_no);
        if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!reset && edge_n >= 0) begin
        chk("held_dut0", bus0.held, held_exp[edge_n]);
        chk("held_dut1", bus1.held, held_exp[edge_n]);
        mon(0, bus0.signal, bus0.signal_long);
        mon(1, bus1.signal, bus1.signal_long);
      end
    end
  end

  initial begin
    bus0.button_raw = 1'b0;
    bus1.button_raw = 1'b1;
    repeat (3) @(posedge clock);
    #1 chk_zero("reset");
    reset = 1'b0;

    hold(1'b1, 12); hold(1'b0, 30);                 // clean short press
    repeat (10) begin hold(1'b1, 3); hold(1'b0, 1); end
    hold(1'b0, 20);                                  // glitch train
    hold(1'b1, 60);  hold(1'b0, 30);                 // long press
    hold(1'b1, 200); hold(1'b0, 30);                 // very long press
    hold(1'b1, 19);  hold(1'b0, 30);                 // release on threshold
    hold(1'b1, 20);  hold(1'b0, 30);                 // release one cycle later

    hold(1'b1, 10);                                  // reset mid-press
    #2 reset = 1'b1;
    #1 chk_zero("midreset");
    q0.delete();
    q1.delete();
    hm = 1'b0;
    h_edge = -100000;
    @(posedge clock);
    @(posedge clock);
    #1 chk_zero("inreset");
    edge_n = -1;
    reset = 1'b0;
    hold(1'b1, 45); hold(1'b0, 30);

    for (int s = 0; s < 40; s++) begin
      bit v;
      int n;
      v = 1'($urandom_range(0, 1));
      n = int'($urandom_range(1, 30));
      hold(v, n);
    end
    hold(1'b0, 40);

    @(negedge clock);
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL pending_dut0 got %0d outstanding expected 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL pending_dut1 got %0d outstanding expected 0", q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
